// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg: shared types for the two-requester ALU arbiter.
// FSM state encoding, requester count and the requester index type.
package alu_arb_pkg;

    localparam int NUM_REQ = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    typedef logic [$clog2(NUM_REQ)-1:0] req_idx_t;

    // One-hot mask with only the bit for the given requester set.
    function automatic logic [NUM_REQ-1:0] idx_to_mask(input req_idx_t idx);
        logic [NUM_REQ-1:0] mask;
        mask      = '0;
        mask[idx] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request/response channels between the requesters and the
// arbiter. master = requester side, slave = arbiter side.
interface alu_arbiter_if import alu_arb_pkg::*; #(
    parameter int W   = 32,
    parameter int OPW = 4
);

    logic [NUM_REQ-1:0]          req_valid;
    logic [NUM_REQ-1:0]          req_ready;
    logic [NUM_REQ-1:0][W-1:0]   req_a;
    logic [NUM_REQ-1:0][W-1:0]   req_b;
    logic [NUM_REQ-1:0][OPW-1:0] req_op;
    logic [NUM_REQ-1:0]          rsp_valid;
    logic [NUM_REQ-1:0]          rsp_ready;
    logic [W-1:0]                rsp_res;
    logic [3:0]                  rsp_flags;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_res, rsp_flags
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_res, rsp_flags
    );

endinterface

// File: rtl/alu.sv
// alu: shared combinational ALU. Op encodings: 0 add, 1 sub, 2 and, 3 or,
// 4 xor, 5 sll, 6 srl; other codes give 0. Flags are {N,Z,C,V}; C and V are
// only meaningful for add/sub. Shift amounts use all of b, so b >= W gives 0.
module alu #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic [OPW-1:0] op,
    output logic [W-1:0]   res,
    output logic [3:0]     flags
);

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_SLL = OPW'(5);
    localparam logic [OPW-1:0] OP_SRL = OPW'(6);

    localparam int SHW = $clog2(W);

    logic [W:0]     wide;
    logic           carry;
    logic           ovf;
    logic           shift_big;
    logic [SHW-1:0] shamt;

    assign shamt     = b[SHW-1:0];
    assign shift_big = |b[W-1:SHW];

    // Evaluate the selected operation and derive the flag bits.
    always_comb begin
        res   = '0;
        wide  = '0;
        carry = 1'b0;
        ovf   = 1'b0;
        case (op)
            OP_ADD: begin
                wide  = {1'b0, a} + {1'b0, b};
                res   = wide[W-1:0];
                carry = wide[W];
                ovf   = (a[W-1] == b[W-1]) && (res[W-1] != a[W-1]);
            end
            OP_SUB: begin
                wide  = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
                res   = wide[W-1:0];
                carry = wide[W];
                ovf   = (a[W-1] != b[W-1]) && (res[W-1] != a[W-1]);
            end
            OP_AND: res = a & b;
            OP_OR:  res = a | b;
            OP_XOR: res = a ^ b;
            OP_SLL: res = shift_big ? '0 : (a << shamt);
            OP_SRL: res = shift_big ? '0 : (a >> shamt);
            default: res = '0;
        endcase
        flags = {res[W-1], (res == '0), carry, ovf};
    end

endmodule

// File: rtl/alu_arb_pick.sv
// alu_arb_pick: combinational grant picker for two requesters.
// Build option ALU_ARB_FIXED_PRIO_EN: requester 0 always wins a tie and the
// prio input does not exist; otherwise ties go to the requester named by prio.
module alu_arb_pick import alu_arb_pkg::*; (
    input  logic [NUM_REQ-1:0] valid,
`ifndef ALU_ARB_FIXED_PRIO_EN
    input  req_idx_t           prio,
`endif
    output req_idx_t           gnt,
    output logic               any
);

    // Pick the winner among the valid requesters.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        gnt = req_idx_t'(0);
        any = |valid;
`ifdef ALU_ARB_FIXED_PRIO_EN
        gnt = valid[0] ? req_idx_t'(0) : req_idx_t'(1);
`else
        case (valid)
            2'b01:   gnt = req_idx_t'(0);
            2'b10:   gnt = req_idx_t'(1);
            2'b11:   gnt = prio;
            default: gnt = req_idx_t'(0);
        endcase
`endif
    end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational alu between two requesters.
// IDLE accepts one request, EXEC registers the ALU output, RESP holds the
// response until the granted requester takes it. One op in flight at a time.
// Build option ALU_ARB_FIXED_PRIO_EN: fixed priority to requester 0 instead of
// round-robin; the prio register is then absent.
module alu_arbiter import alu_arb_pkg::*; #(
    parameter int W   = 32,
    parameter int OPW = 4
) (
    input  logic          clk,
    input  logic          rst,
    alu_arbiter_if.slave  bus,
    output logic          busy
);

    state_t             state;
    req_idx_t           gnt;
`ifndef ALU_ARB_FIXED_PRIO_EN
    req_idx_t           prio;
`endif
    logic [W-1:0]       a_q;
    logic [W-1:0]       b_q;
    logic [OPW-1:0]     op_q;
    logic [W-1:0]       res_q;
    logic [3:0]         flags_q;
    logic [NUM_REQ-1:0] rsp_valid_q;

    req_idx_t           pick_gnt;
    logic               pick_any;
    logic [W-1:0]       alu_res;
    logic [3:0]         alu_flags;

    alu_arb_pick u_pick (
        .valid (bus.req_valid),
`ifndef ALU_ARB_FIXED_PRIO_EN
        .prio  (prio),
`endif
        .gnt   (pick_gnt),
        .any   (pick_any)
    );

    alu #(
        .W   (W),
        .OPW (OPW)
    ) u_alu (
        .a     (a_q),
        .b     (b_q),
        .op    (op_q),
        .res   (alu_res),
        .flags (alu_flags)
    );

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_res   = res_q;
    assign bus.rsp_flags = flags_q;

    // Accept strobe: only in IDLE, never while reset is asserted.
    always_comb begin
        bus.req_ready = '0;
        if (!rst && (state == IDLE) && pick_any) begin
            bus.req_ready = idx_to_mask(pick_gnt);
        end
    end

    // Sequencer: capture operands, register the ALU output, hold the response.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: operand and result registers are cleared as well, so a
            // dropped op leaves no trace on the response bus.
            state       <= IDLE;
            gnt         <= req_idx_t'(0);
`ifndef ALU_ARB_FIXED_PRIO_EN
            prio        <= req_idx_t'(0);
`endif
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            res_q       <= '0;
            flags_q     <= '0;
            rsp_valid_q <= '0;
            busy        <= 1'b0;
        end else begin
            // NOTE: all registered state is written with non-blocking
            // assignments so every branch sees the pre-edge values.
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        a_q   <= bus.req_a[pick_gnt];
                        b_q   <= bus.req_b[pick_gnt];
                        op_q  <= bus.req_op[pick_gnt];
                        gnt   <= pick_gnt;
`ifndef ALU_ARB_FIXED_PRIO_EN
                        prio  <= ~pick_gnt;
`endif
                        state <= EXEC;
                        busy  <= 1'b1;
                    end
                end
                EXEC: begin
                    res_q       <= alu_res;
                    flags_q     <= alu_flags;
                    rsp_valid_q <= idx_to_mask(gnt);
                    state       <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready[gnt]) begin
                        rsp_valid_q <= '0;
                        state       <= IDLE;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    rsp_valid_q <= '0;
                    state       <= IDLE;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed bench for alu_arbiter. Inputs change 1 time unit
// after the rising edge; outputs are compared 2 units later, mid-cycle.
module tb_alu_arbiter;

    logic clk;
    logic rst;
    logic busy;
    int   checks;
    int   failures;

`ifdef ALU_ARB_FIXED_PRIO_EN
    localparam logic [1:0]  SECOND_GNT = 2'b01;
    localparam logic [31:0] SECOND_RES = 32'h0000_0038;
`else
    localparam logic [1:0]  SECOND_GNT = 2'b10;
    localparam logic [31:0] SECOND_RES = 32'h0000_003f;
`endif

    alu_arbiter_if #(.W(32), .OPW(4)) bus ();

    alu_arbiter #(
        .W   (32),
        .OPW (4)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .busy (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.req_op[idx] = op;
        bus.req_a[idx]  = a;
        bus.req_b[idx]  = b;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = '0;

        // 1: reset state, then a single AND from req0
        set_req(0, 4'd2, 32'hffff_ffff, 32'h0);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b11;
        cyc(); #2;
        check("rst_req_ready", bus.req_ready, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", bus.rsp_valid, 2'b00);
        check("rst_rsp_res", bus.rsp_res, 32'h0);
        check("rst_rsp_flags", bus.rsp_flags, 4'b0000);
        cyc(); rst = 1'b0; #2;
        check("t1_accept", bus.req_ready, 2'b01);
        check("t1_idle_busy", busy, 1'b0);
        cyc(); bus.req_valid = 2'b00; #2;
        check("t1_exec_ready", bus.req_ready, 2'b00);
        check("t1_exec_busy", busy, 1'b1);
        check("t1_exec_rsp_valid", bus.rsp_valid, 2'b00);
        cyc(); #2;
        check("t1_rsp_valid", bus.rsp_valid, 2'b01);
        check("t1_rsp_res", bus.rsp_res, 32'h0);
        check("t1_rsp_flags", bus.rsp_flags, 4'b0100);
        cyc(); #2;
        check("t1_done_rsp_valid", bus.rsp_valid, 2'b00);
        check("t1_done_busy", busy, 1'b0);

        // 2: both requesters valid from reset, grants alternate
        cyc(); rst = 1'b1;
        set_req(0, 4'd3, 32'h0, 32'h38);
        set_req(1, 4'd4, 32'h15, 32'h2a);
        bus.req_valid = 2'b11;
        #2;
        check("t2_rst_ready", bus.req_ready, 2'b00);
        cyc(); rst = 1'b0; #2;
        check("t2_g1_ready", bus.req_ready, 2'b01);
        cyc(); cyc(); #2;
        check("t2_g1_rsp_valid", bus.rsp_valid, 2'b01);
        check("t2_g1_res", bus.rsp_res, 32'h38);
        check("t2_g1_flags", bus.rsp_flags, 4'b0000);
        check("t2_g1_resp_ready", bus.req_ready, 2'b00);
        cyc(); #2;
        check("t2_g2_ready", bus.req_ready, SECOND_GNT);
        cyc(); cyc(); #2;
        check("t2_g2_rsp_valid", bus.rsp_valid, SECOND_GNT);
        check("t2_g2_res", bus.rsp_res, SECOND_RES);
        check("t2_g2_flags", bus.rsp_flags, 4'b0000);
        cyc(); #2;
        check("t2_g3_ready", bus.req_ready, 2'b01);
        cyc(); cyc(); #2;
        check("t2_g3_rsp_valid", bus.rsp_valid, 2'b01);
        check("t2_g3_res", bus.rsp_res, 32'h38);
        cyc(); #2;
        check("t2_g4_ready", bus.req_ready, SECOND_GNT);
        cyc(); bus.req_valid = 2'b00;
        cyc(); #2;
        check("t2_g4_rsp_valid", bus.rsp_valid, SECOND_GNT);

        // 3: backpressure on req1 while req0 waits
        cyc();
        set_req(1, 4'd5, 32'hf, 32'd31);
        bus.req_valid = 2'b10;
        bus.rsp_ready = 2'b00;
        #2;
        check("t3_accept", bus.req_ready, 2'b10);
        cyc();
        set_req(0, 4'd3, 32'h0, 32'h38);
        bus.req_valid = 2'b01;
        #2;
        check("t3_exec_ready", bus.req_ready, 2'b00);
        cyc();
        for (int i = 0; i < 5; i++) begin
            bus.rsp_ready = (i >= 2) ? 2'b01 : 2'b00;
            #2;
            check("t3_hold_rsp_valid", bus.rsp_valid, 2'b10);
            check("t3_hold_res", bus.rsp_res, 32'h8000_0000);
            check("t3_hold_flags", bus.rsp_flags, 4'b1000);
            check("t3_hold_ready", bus.req_ready, 2'b00);
            check("t3_hold_busy", busy, 1'b1);
            cyc();
        end
        bus.rsp_ready = 2'b10;
        #2;
        check("t3_hs_rsp_valid", bus.rsp_valid, 2'b10);
        check("t3_hs_ready", bus.req_ready, 2'b00);
        cyc(); #2;
        check("t3_after_rsp_valid", bus.rsp_valid, 2'b00);
        check("t3_after_busy", busy, 1'b0);
        check("t3_r0_accept", bus.req_ready, 2'b01);
        cyc(); bus.req_valid = 2'b00; bus.rsp_ready = 2'b11;
        cyc(); #2;
        check("t3_r0_rsp_valid", bus.rsp_valid, 2'b01);
        check("t3_r0_res", bus.rsp_res, 32'h38);

        // 4: reset while in EXEC drops the op
        cyc();
        set_req(0, 4'd6, 32'hf, 32'h3);
        bus.req_valid = 2'b01;
        #2;
        check("t4_accept", bus.req_ready, 2'b01);
        cyc(); bus.req_valid = 2'b00; rst = 1'b1; #2;
        check("t4_exec_busy", busy, 1'b1);
        cyc(); rst = 1'b0;
        set_req(0, 4'd4, 32'h15, 32'h2a);
        set_req(1, 4'd3, 32'h0, 32'h38);
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b00;
        #2;
        check("t4_rst_rsp_valid", bus.rsp_valid, 2'b00);
        check("t4_rst_res", bus.rsp_res, 32'h0);
        check("t4_rst_flags", bus.rsp_flags, 4'b0000);
        check("t4_rst_busy", busy, 1'b0);
        check("t4_prio_reset", bus.req_ready, 2'b01);

        // 5: req0 pulse during RESP is not accepted
        cyc(); bus.req_valid = 2'b00; #2;
        check("t4_no_rsp", bus.rsp_valid, 2'b00);
        check("t4_no_rsp_res", bus.rsp_res, 32'h0);
        cyc(); bus.req_valid = 2'b01; #2;
        check("t5_rsp_valid", bus.rsp_valid, 2'b01);
        check("t5_rsp_res", bus.rsp_res, 32'h3f);
        check("t5_pulse_ready", bus.req_ready, 2'b00);
        cyc(); bus.req_valid = 2'b00; bus.rsp_ready = 2'b01; #2;
        check("t5_held_rsp_valid", bus.rsp_valid, 2'b01);
        cyc(); bus.rsp_ready = 2'b00; #2;
        check("t5_done_rsp_valid", bus.rsp_valid, 2'b00);
        check("t5_done_busy", busy, 1'b0);
        cyc(); #2;
        check("t5_no_extra_busy", busy, 1'b0);
        check("t5_no_extra_rsp", bus.rsp_valid, 2'b00);

        // 6: back-to-back shifts from req0, 3-cycle accept spacing
        cyc();
        set_req(0, 4'd6, 32'h1, 32'h1);
        bus.req_valid = 2'b01;
        bus.rsp_ready = 2'b11;
        #2;
        check("t6_a1_ready", bus.req_ready, 2'b01);
        cyc(); set_req(0, 4'd5, 32'hf, 32'd32); #2;
        check("t6_exec_ready", bus.req_ready, 2'b00);
        cyc(); #2;
        check("t6_r1_rsp_valid", bus.rsp_valid, 2'b01);
        check("t6_r1_res", bus.rsp_res, 32'h0);
        check("t6_r1_flags", bus.rsp_flags, 4'b0100);
        check("t6_hs_ready", bus.req_ready, 2'b00);
        cyc(); #2;
        check("t6_a2_ready", bus.req_ready, 2'b01);
        cyc(); bus.req_valid = 2'b00;
        cyc(); #2;
        check("t6_r2_rsp_valid", bus.rsp_valid, 2'b01);
        check("t6_r2_res", bus.rsp_res, 32'h0);
        check("t6_r2_flags", bus.rsp_flags, 4'b0100);
        cyc(); #2;
        check("t6_end_rsp_valid", bus.rsp_valid, 2'b00);
        check("t6_end_busy", busy, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one combinational `alu` instance between two requesters, e.g. a datapath issue slot and a debug/CSR unit.
- Each requester issues {a, b, op} over a valid/ready request channel.
- Each requester receives {res, flags} over a valid/ready response channel.
- A 3-state FSM sequences the shared ALU, allowing one operation in flight at a time.
- Round-robin arbitration by default.

Parameters:
- W, 32, operand/result width passed to the `alu` instance.
- OPW, 4, ALU op-code width.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  [1:0]  per-requester request valid.
- req_ready  out  [1:0]  per-requester request accepted (one-hot or zero).
- req_a  in  [1:0][W-1:0]  operand a per requester.
- req_b  in  [1:0][W-1:0]  operand b per requester.
- req_op  in  [1:0][OPW-1:0]  ALU op per requester (encodings from the shared ALU header: 2 and, 3 or, 4 xor, 5 sll, 6 srl, ...).
- rsp_valid  out  [1:0]  response valid, asserted only for the granted requester.
- rsp_ready  in  [1:0]  per-requester response accept.
- rsp_res  out  W  registered ALU result, shared by both requesters.
- rsp_flags  out  4  registered ALU flags {N,Z,C,V}, shared by both requesters.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, prio=0, gnt=0, operand regs 0, rsp_res=0, rsp_flags=0, rsp_valid=0, busy=0. req_ready is 0 during the reset cycle.
- Reset mid-operation: in EXEC or RESP, the pending op is dropped. No rsp_valid is produced afterwards.
- States:
  - IDLE: if any req_valid, choose g and drive req_ready[g]=1 combinationally that cycle. Register req_a/b/op[g] into the operand regs, set gnt<=g, go EXEC. If no req_valid, stay in IDLE.
  - EXEC: the ALU is driven from the operand regs. Register res/flags into rsp_res/rsp_flags, go RESP.
  - RESP: rsp_valid[gnt]=1 and rsp_valid[~gnt]=0. rsp_res/rsp_flags are held stable. On rsp_ready[gnt], go IDLE. Otherwise stay in RESP indefinitely (backpressure).
- Arbitration:
  - If only one requester is valid, it is granted.
  - If both are valid, requester prio is granted.
  - On every accept, prio <= ~g.
- Latency: accept at cycle 0, rsp_valid at cycle 2. Minimum 3 cycles per operation.
- No new request is accepted in the cycle a response handshake completes.
- req_ready is never asserted outside IDLE.
- Requester obligation: hold {a, b, op} stable while req_valid is high until accepted. Dropping req_valid before acceptance is legal; nothing is captured.
- Unsupported op codes are forwarded to the ALU unchanged. The result is whatever the ALU produces.
- rsp_ready of the non-granted requester is ignored.

Optional Feature:
Macro `ALU_ARB_FIXED_PRIO_EN`.
- Defined: requester 0 always wins when both are valid. The prio register is not implemented.
- Undefined: round-robin as described in Behaviour.

Decomposition:
- Package alu_arb_pkg holds:
  - state enum {IDLE, EXEC, RESP}.
  - NUM_REQ=2.
  - requester index typedef.
- ALU op encodings stay in the existing shared ALU header.
- One natural sub-module: alu_arb_pick, a combinational grant picker (valid[1:0], prio → gnt, any), containing the `ALU_ARB_FIXED_PRIO_EN` switch.
- The `alu` instance is used unmodified.

Test Plan:
1. After reset, req0 issues op=2, a=ffffffff, b=0, with rsp_ready=1 → req_ready[0] in cycle 0; rsp_valid[0] at cycle 2 with rsp_res=0, rsp_flags=0100; rsp_valid[1]=0 throughout.
2. Both requesters valid from reset: req0 op=3 a=0 b=38, req1 op=4 a=15 b=2a → req0 granted first with res=38, flags=0000; then req1 with res=3f, flags=0000. Continuous requests alternate 0,1,0,1. With `ALU_ARB_FIXED_PRIO_EN`, req0 wins every time.
3. Backpressure: req1 op=5 a=f b=31 with rsp_ready[1]=0 for 5 cycles → rsp_valid[1] held with res=80000000, flags=1000 stable. req_ready stays 00 despite req0 valid. busy=1 until handshake.
4. Reset asserted in EXEC for an op=6 a=f b=3 → next cycle state IDLE, rsp_valid=00, rsp_res=0, and no response ever appears.
5. req_valid[0] pulsed for one cycle while a response is pending in RESP → never accepted. No extra response is generated.
6. Sequence of op=6 a=1 b=1 then op=5 a=f b=32 from req0 → res=0, flags=0100 both times. Each operation has a 3-cycle accept-to-accept spacing.
